// File: rtl/jacaranda_loader_pkg.sv
// jacaranda_loader_pkg: shared state encoding and SPI constants for the jacaranda-8 flash boot loader
package jacaranda_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        FINISH = 3'd4
    } state_e;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int         CMD_BITS     = 8;
    localparam int         ADDR_BITS    = 24;

    // Byte i (0 = most significant) of a 24-bit flash address
    function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] i);
        return i == 2'd0 ? a[23:16] : i == 2'd1 ? a[15:8] : a[7:0];
    endfunction

endpackage

// File: rtl/jacaranda_spi_shifter.sv
// jacaranda_spi_shifter: SPI mode-0 SCK generator with an 8-bit transmit/receive shift register
module jacaranda_spi_shifter
    import jacaranda_loader_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       en,
    input  logic       run,
    input  logic       miso,
    input  logic [7:0] tx_next,
    output logic       sck,
    output logic       mosi,
    output logic       bit_done,
    output logic       byte_done,
    output logic       tail,
    output logic [7:0] rx_byte
);

    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_q, tx_d;
    logic [6:0]    rx_q, rx_d;
    logic          tick, rise, fall;

    // A half-period tick; rising edges only while run, the pending falling edge always completes,
    // and tail marks one full low half-period after SCK has stopped
    assign tick      = en && cnt_q == CW'(CLK_DIV - 1);
    assign rise      = tick && !sck_q && run;
    assign fall      = tick && sck_q;
    assign tail      = tick && !sck_q && !run;
    assign bit_done  = rise;
    assign byte_done = rise && bit_q == 3'(CMD_BITS - 1);
    assign rx_byte   = {rx_q, miso};
    assign sck       = sck_q;
    assign mosi      = tx_q[7];

    // Next-state: the next byte is preloaded while idle and swapped in on the falling edge after a byte boundary
    always_comb begin
        cnt_d = !en || tick ? '0 : cnt_q + CW'(1);
        sck_d = en && (rise || (sck_q && !fall));
        bit_d = !en ? 3'd0 : rise ? bit_q + 3'd1 : bit_q;
        rx_d  = rise ? {rx_q[5:0], miso} : rx_q;
        tx_d  = !en ? tx_next : fall ? (bit_q == 3'd0 ? tx_next : {tx_q[6:0], 1'b0}) : tx_q;
    end

    // Shifter state registers
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
            bit_q <= 3'd0;
            tx_q  <= 8'h00;
            rx_q  <= 7'h00;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
            bit_q <= bit_d;
            tx_q  <= tx_d;
            rx_q  <= rx_d;
        end
    end

endmodule

// File: rtl/jacaranda_flash_boot_loader.sv
// jacaranda_flash_boot_loader: holds jacaranda-8 in reset, copies an image from SPI flash into imem, then releases it
// Optional feature: define JACARANDA_LOADER_CHECKSUM_EN for a mod-256 checksum of the loaded bytes.
module jacaranda_flash_boot_loader
    import jacaranda_loader_pkg::*;
#(
    parameter int          IMEM_AW    = 8,
    parameter logic [23:0] FLASH_BASE = 24'h010000,
    parameter int          CLK_DIV    = 2
) (
    input  logic               clock,
    input  logic               resetb,
    input  logic               start,
    input  logic [IMEM_AW:0]   len,
    output logic               busy,
    output logic               done,
    output logic               cpu_resetb,
    output logic               spi_csb,
    output logic               spi_sck,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [7:0]         imem_wdata,
    output logic [7:0]         checksum
);

    localparam logic [1:0] ADDR_LAST = 2'(ADDR_BITS / 8 - 1);

    state_e             state_q, state_d;
    logic [IMEM_AW:0]   len_q, len_d;
    logic [IMEM_AW:0]   idx_q, idx_d;
    logic [1:0]         bc_q, bc_d;
    logic               stop_q, stop_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cpu_resetb_q, cpu_resetb_d;
    logic               csb_q, csb_d;
    logic               we_q, we_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         tx_next, rx_byte;
    logic               bit_done, byte_done, tail, byte_evt;
    logic [IMEM_AW:0]   idx_nxt;

    assign tx_next  = state_q == ADDR ? addr_byte(FLASH_BASE, bc_q) : state_q == DATA ? 8'h00 : SPI_CMD_READ;
    assign byte_evt = bit_done && byte_done;
    assign idx_nxt  = idx_q + 1'b1;

    jacaranda_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clock     (clock),
        .resetb    (resetb),
        .en        (!csb_q),
        .run       (!stop_q),
        .miso      (spi_miso),
        .tx_next   (tx_next),
        .sck       (spi_sck),
        .mosi      (spi_mosi),
        .bit_done  (bit_done),
        .byte_done (byte_done),
        .tail      (tail),
        .rx_byte   (rx_byte)
    );

    // Load sequencer: header bytes, burst data bytes written as they complete, then a one-cycle release
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        bc_d         = bc_q;
        stop_d       = stop_q;
        busy_d       = busy_q;
        done_d       = done_q;
        cpu_resetb_d = cpu_resetb_q;
        csb_d        = csb_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if (state_q == IDLE) begin
            if (start) begin
                len_d        = len;
                idx_d        = '0;
                bc_d         = 2'd0;
                stop_d       = 1'b0;
                busy_d       = 1'b1;
                done_d       = 1'b0;
                cpu_resetb_d = 1'b0;
                csb_d        = len == '0;
                state_d      = len == '0 ? FINISH : CMD;
            end
        end else if (state_q == CMD) begin
            if (byte_evt) state_d = ADDR;
        end else if (state_q == ADDR) begin
            if (byte_evt) begin
                bc_d = bc_q + 2'd1;
                if (bc_q == ADDR_LAST) state_d = DATA;
            end
        end else if (state_q == DATA) begin
            if (byte_evt) begin
                we_d    = 1'b1;
                addr_d  = idx_q[IMEM_AW-1:0];
                wdata_d = rx_byte;
                idx_d   = idx_nxt;
                if (idx_nxt == len_q) stop_d = 1'b1;
            end
            if (stop_q && tail) begin
                state_d = FINISH;
                csb_d   = 1'b1;
            end
        end else begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            cpu_resetb_d = 1'b1;
            csb_d        = 1'b1;
        end
    end

    // Sequencer registers; reset drops the load and keeps the core held
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            bc_q         <= 2'd0;
            stop_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cpu_resetb_q <= 1'b0;
            csb_q        <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            bc_q         <= bc_d;
            stop_q       <= stop_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cpu_resetb_q <= cpu_resetb_d;
            csb_q        <= csb_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cpu_resetb = cpu_resetb_q;
    assign spi_csb    = csb_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

`ifdef JACARANDA_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Running sum of every written byte, restarted by an accepted load
    always_comb sum_d = state_q == IDLE && start ? 8'h00 : we_q ? sum_q + wdata_q : sum_q;

    // Checksum register
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) sum_q <= 8'h00;
        else         sum_q <= sum_d;
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_jacaranda_flash_boot_loader.sv
// tb_jacaranda_flash_boot_loader: three loaders (CLK_DIV 1,2,3) against an SPI flash model and an image-copy reference
module tb_jacaranda_flash_boot_loader;

    localparam int          AW   = 8;
    localparam logic [23:0] BASE = 24'h010000;
    localparam int          NI   = 3;
`ifdef JACARANDA_LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          resetb = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          busy [NI];
    logic          done [NI];
    logic          cpu_resetb [NI];
    logic          spi_csb [NI];
    logic          spi_sck [NI];
    logic          spi_mosi [NI];
    logic          spi_miso [NI];
    logic          imem_we [NI];
    logic [AW-1:0] imem_addr [NI];
    logic [7:0]    imem_wdata [NI];
    logic [7:0]    checksum [NI];

    logic [7:0] img [256];
    int         checks = 0;
    int         errors = 0;
    int         exp_len = 0;
    logic [7:0] exp_sum = 8'h00;
    int         load_id = 0;
    event       chk_end;

    always #5 clock = ~clock;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] img_sum(input int n);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < n; i++) s = s + img[i];
        return s;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int DIV = g + 1;

        jacaranda_flash_boot_loader #(.IMEM_AW(AW), .FLASH_BASE(BASE), .CLK_DIV(DIV)) dut (
            .clock      (clock),
            .resetb     (resetb),
            .start      (start),
            .len        (len),
            .busy       (busy[g]),
            .done       (done[g]),
            .cpu_resetb (cpu_resetb[g]),
            .spi_csb    (spi_csb[g]),
            .spi_sck    (spi_sck[g]),
            .spi_mosi   (spi_mosi[g]),
            .spi_miso   (spi_miso[g]),
            .imem_we    (imem_we[g]),
            .imem_addr  (imem_addr[g]),
            .imem_wdata (imem_wdata[g]),
            .checksum   (checksum[g])
        );

        int          nrise = 0;
        logic [31:0] hdr = '0;
        logic [7:0]  fb;
        int          wr_cnt = 0, win_cnt = 0, seen_id = 0, cyc = 0;
        int          rise_t = -1000, fall_t = -1000, csbf_t = 0;
        logic        p_sck = 1'b0, p_mosi = 1'b0, p_csb = 1'b1;

        initial spi_miso[g] = 1'b0;

        // Flash: 32 header bits in on rising SCK, then image bytes out MSB first after each falling SCK
        always @(negedge spi_csb[g]) nrise = 0;
        always @(posedge spi_sck[g]) if (!spi_csb[g]) begin
            if (nrise < 32) hdr = {hdr[30:0], spi_mosi[g]};
            nrise++;
            if (nrise == 32) chk($sformatf("i%0d_header", g), hdr, {8'h03, BASE});
        end
        always @(negedge spi_sck[g]) if (!spi_csb[g] && nrise >= 32) begin
            fb = img[((nrise - 32) / 8) % 256];
            spi_miso[g] = fb[7 - (nrise - 32) % 8];
        end

        // Per-cycle checks: writes against the image, SCK timing, mosi stability, core held while busy
        always @(negedge clock) begin
            cyc++;
            if (seen_id != load_id) begin
                seen_id = load_id;
                wr_cnt  = 0;
                win_cnt = 0;
            end
            if (resetb) begin
                if (imem_we[g]) begin
                    chk($sformatf("i%0d_wr_bound", g), wr_cnt < exp_len, 1);
                    chk($sformatf("i%0d_wr_addr", g), imem_addr[g], wr_cnt % 256);
                    chk($sformatf("i%0d_wr_data", g), imem_wdata[g], img[wr_cnt % 256]);
                    wr_cnt++;
                end
                if (busy[g]) chk($sformatf("i%0d_core_held", g), cpu_resetb[g], 0);
                if (spi_mosi[g] != p_mosi) chk($sformatf("i%0d_mosi_while_sck_high", g), spi_sck[g], 0);
                if (p_csb && !spi_csb[g]) begin
                    win_cnt++;
                    csbf_t = cyc;
                end
                if (!p_sck && spi_sck[g]) begin
                    chk($sformatf("i%0d_rise_csb", g), spi_csb[g], 0);
                    if (rise_t < csbf_t) chk($sformatf("i%0d_lead", g), cyc - csbf_t >= DIV, 1);
                    else chk($sformatf("i%0d_period", g), cyc - rise_t, 2 * DIV);
                    rise_t = cyc;
                end
                if (p_sck && !spi_sck[g]) begin
                    chk($sformatf("i%0d_high_time", g), cyc - rise_t, DIV);
                    fall_t = cyc;
                end
                if (!p_csb && spi_csb[g]) begin
                    chk($sformatf("i%0d_trail", g), cyc - fall_t >= DIV, 1);
                    chk($sformatf("i%0d_sck_at_csb", g), spi_sck[g], 0);
                end
            end
            p_sck  = spi_sck[g];
            p_mosi = spi_mosi[g];
            p_csb  = spi_csb[g];
        end

        // End-of-load checks against the reference
        always @(chk_end) begin
            chk($sformatf("i%0d_wr_count", g), wr_cnt, exp_len);
            chk($sformatf("i%0d_csb_windows", g), win_cnt, exp_len != 0);
            chk($sformatf("i%0d_done", g), done[g], 1);
            chk($sformatf("i%0d_cpu_resetb", g), cpu_resetb[g], 1);
            chk($sformatf("i%0d_busy", g), busy[g], 0);
            chk($sformatf("i%0d_csb", g), spi_csb[g], 1);
            chk($sformatf("i%0d_checksum", g), checksum[g], CS_EN ? exp_sum : 8'h00);
        end
    end

    task automatic begin_load(input int n);
        @(negedge clock);
        start   = 1'b1;
        len     = (AW + 1)'(n);
        exp_len = n;
        exp_sum = img_sum(n);
        load_id++;
        @(negedge clock);
        start = 1'b0;
        len   = (AW + 1)'($urandom);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("i%0d_busy_on_start", k), busy[k], 1);
            chk($sformatf("i%0d_done_cleared", k), done[k], 0);
            chk($sformatf("i%0d_core_reset_on_start", k), cpu_resetb[k], 0);
        end
    endtask

    task automatic finish_load(input int budget);
        bit all;
        all = 1'b0;
        for (int c = 0; c < budget && !all; c++) begin
            @(negedge clock);
            all = 1'b1;
            for (int k = 0; k < NI; k++) if (busy[k] || !done[k]) all = 1'b0;
        end
        chk("load_complete_in_time", all, 1);
        #2 -> chk_end;
        #1;
    endtask

    function automatic int budget_for(input int n);
        return (32 + 8 * n) * 2 * NI + 50;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        #1 resetb = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("i%0d_rst_busy", k), busy[k], 0);
            chk($sformatf("i%0d_rst_done", k), done[k], 0);
            chk($sformatf("i%0d_rst_cpu_resetb", k), cpu_resetb[k], 0);
            chk($sformatf("i%0d_rst_csb", k), spi_csb[k], 1);
            chk($sformatf("i%0d_rst_sck", k), spi_sck[k], 0);
            chk($sformatf("i%0d_rst_mosi", k), spi_mosi[k], 0);
            chk($sformatf("i%0d_rst_we", k), imem_we[k], 0);
            chk($sformatf("i%0d_rst_addr", k), imem_addr[k], 0);
            chk($sformatf("i%0d_rst_wdata", k), imem_wdata[k], 0);
            chk($sformatf("i%0d_rst_checksum", k), checksum[k], 0);
        end
        repeat (3) @(negedge clock);
        resetb = 1'b1;

        img[0] = 8'h11;
        img[1] = 8'h22;
        img[2] = 8'h33;
        begin_load(3);
        finish_load(budget_for(3));
        chk("t1_last_addr", imem_addr[0], 2);
        chk("t1_last_data", imem_wdata[0], 8'h33);
        chk("t1_checksum_literal", checksum[0], CS_EN ? 8'h66 : 8'h00);

        begin_load(0);
        finish_load(3);

        for (int i = 0; i < 256; i++) img[i] = 8'(i);
        begin_load(256);
        finish_load(budget_for(256));
        chk("t3_last_addr", imem_addr[0], 255);
        chk("t3_last_data", imem_wdata[0], 8'hFF);
        chk("t3_checksum_literal", checksum[0], CS_EN ? 8'h80 : 8'h00);

        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        begin_load(4);
        for (int c = 0; c < budget_for(4) && inst[0].wr_cnt < 1; c++) @(negedge clock);
        chk("t4_reached_byte1", inst[0].wr_cnt, 1);
        start = 1'b1;
        len   = 9'd9;
        @(negedge clock);
        start = 1'b0;
        finish_load(budget_for(4));

        begin_load(5);
        for (int c = 0; c < budget_for(5) && inst[0].wr_cnt < 2; c++) @(negedge clock);
        chk("t5_reached_byte2", inst[0].wr_cnt, 2);
        #2 resetb = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("i%0d_t5_csb", k), spi_csb[k], 1);
            chk($sformatf("i%0d_t5_cpu_resetb", k), cpu_resetb[k], 0);
            chk($sformatf("i%0d_t5_done", k), done[k], 0);
            chk($sformatf("i%0d_t5_sck", k), spi_sck[k], 0);
            chk($sformatf("i%0d_t5_we", k), imem_we[k], 0);
        end
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        begin_load(5);
        finish_load(budget_for(5));

        for (int t = 0; t < 6; t++) begin
            int n;
            for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
            n = $urandom_range(1, 24);
            repeat ($urandom_range(0, 5)) @(negedge clock);
            begin_load(n);
            finish_load(budget_for(n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
